// File: rtl/rshift_round_sat_pkg.sv
// Shared fixed-point constants and saturation helpers for the FFT datapath.
// Latency: n/a (package).
// Backpressure: n/a.
package rshift_round_sat_pkg;

    localparam int FXP_DATA_WIDTH    = 16;
    // Narrowing and widening shifts must stay paired across the stage.
    localparam int FXP_RSHIFT        = 8;
    localparam int FXP_LSHIFT        = FXP_RSHIFT;
    localparam int FXP_SAT_CNT_WIDTH = 16;

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Low w bits of the complement of max are 100..0, the most negative value.
    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/rshift_round_sat_if.sv
// Handshake bus of the narrowing stage: wide input, narrow output, saturation stats.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides.
interface rshift_round_sat_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int SAT_CNT_WIDTH = 16
);
    logic [2*DATA_WIDTH-1:0]  D_in;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    D_out;
    logic                     out_valid;
    logic                     out_ready;
    logic                     sat_flag;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt;
    logic                     sat_clr;

    modport master (
        output D_in, in_valid, out_ready, sat_clr,
        input  in_ready, D_out, out_valid, sat_flag, sat_cnt
    );

    modport slave (
        input  D_in, in_valid, out_ready, sat_clr,
        output in_ready, D_out, out_valid, sat_flag, sat_cnt
    );
endinterface

// File: rtl/rshift_round_sat_sat_clamp.sv
// Clamp a wide signed value into OUT_W signed bits, flagging when it clipped.
// Latency: combinational.
// Backpressure: none.
module sat_clamp
    import rshift_round_sat_pkg::*;
#(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0] i_dat,
    output logic [OUT_W-1:0]       o_dat,
    output logic                   o_sat
);

    logic [IN_W-OUT_W:0] w_hi;

    // The value fits only if every bit above the output sign bit repeats it.
    assign w_hi  = i_dat[IN_W-1:OUT_W-1];
    assign o_sat = ~((&w_hi) | (~|w_hi));

    always_comb begin
        o_dat = i_dat[OUT_W-1:0];
        if (o_sat) begin
            o_dat = i_dat[IN_W-1] ? OUT_W'(sat_min(OUT_W)) : OUT_W'(sat_max(OUT_W));
        end
    end

endmodule

// File: rtl/rshift_round_sat.sv
// Narrow a 2W signed word: arithmetic right shift, round half-up, saturate to W bits.
// Latency: 2 cycles, 1 word/cycle.
// Backpressure: whole pipeline holds while out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
module rshift_round_sat
    import rshift_round_sat_pkg::*;
#(
    parameter int DATA_WIDTH    = FXP_DATA_WIDTH,
    parameter int RSHIFT_AMOUNT = FXP_RSHIFT,
    parameter int SAT_CNT_WIDTH = FXP_SAT_CNT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    rshift_round_sat_if.slave   bus
);

    localparam int WW = 2*DATA_WIDTH + 1;

    logic                     w_en;
    logic signed [WW-1:0]     w_ext;
    logic signed [WW-1:0]     w_rnd;
    logic [DATA_WIDTH-1:0]    w_clamp;
    logic                     w_sat;
    logic                     w_sat_hs;

    logic                     r_v1;
    logic signed [WW-1:0]     r_r1;
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_dout;
    logic                     r_s2;
    logic                     r_sat_flag;
    logic [SAT_CNT_WIDTH-1:0] r_sat_cnt;

    assign w_en  = ~r_out_valid | bus.out_ready;
    // One guard bit keeps the rounding add from wrapping at full-scale positive.
    assign w_ext = $signed({bus.D_in[2*DATA_WIDTH-1], bus.D_in});

    generate
        if (RSHIFT_AMOUNT == 0) begin : g_noshift
            assign w_rnd = w_ext;
        end else begin : g_shift
            localparam logic signed [WW-1:0] RND = {{(WW-1){1'b0}}, 1'b1} << (RSHIFT_AMOUNT - 1);
            logic signed [WW-1:0] w_sum;
            assign w_sum = w_ext + RND;
            assign w_rnd = w_sum >>> RSHIFT_AMOUNT;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_r1 <= '0;
        end else if (w_en) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) r_r1 <= w_rnd;
        end
    end

    sat_clamp #(
        .IN_W  (WW),
        .OUT_W (DATA_WIDTH)
    ) u_sat_clamp (
        .i_dat (r_r1),
        .o_dat (w_clamp),
        .o_sat (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_s2        <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_dout <= w_clamp;
                r_s2   <= w_sat;
            end
        end
    end

    // Only delivered words count, so stalls and bubbles never inflate the stats.
    assign w_sat_hs = r_out_valid & bus.out_ready & r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flag <= 1'b0;
            r_sat_cnt  <= '0;
        end else if (bus.sat_clr) begin
            r_sat_flag <= w_sat_hs;
            r_sat_cnt  <= w_sat_hs ? SAT_CNT_WIDTH'(1) : '0;
        end else if (w_sat_hs) begin
            r_sat_flag <= 1'b1;
            if (~&r_sat_cnt) r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_valid;
    assign bus.D_out     = r_dout;
    assign bus.sat_flag  = r_sat_flag;
    assign bus.sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_rshift_round_sat.sv
// Bench for rshift_round_sat: scoreboard model on the default build plus directed
// checks on a 4-bit-counter build and a zero-shift build.
module tb_rshift_round_sat;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rshift_round_sat_if #(.DATA_WIDTH(16), .SAT_CNT_WIDTH(16)) ifa ();
    rshift_round_sat_if #(.DATA_WIDTH(16), .SAT_CNT_WIDTH(4))  ifb ();
    rshift_round_sat_if #(.DATA_WIDTH(16), .SAT_CNT_WIDTH(16)) ifc ();

    rshift_round_sat #(.DATA_WIDTH(16), .RSHIFT_AMOUNT(8), .SAT_CNT_WIDTH(16))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rshift_round_sat #(.DATA_WIDTH(16), .RSHIFT_AMOUNT(8), .SAT_CNT_WIDTH(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    rshift_round_sat #(.DATA_WIDTH(16), .RSHIFT_AMOUNT(0), .SAT_CNT_WIDTH(16))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, floor((x + 2^(sh-1)) / 2^sh), then clamp.
    function automatic void model(input logic [31:0] x, input int sh, input int w,
                                  output logic [15:0] d, output bit sat);
        longint v, mx, mn;
        v = longint'($signed(x));
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -(longint'(1) << (w - 1));
        sat = (v > mx) || (v < mn);
        if (v > mx) v = mx;
        else if (v < mn) v = mn;
        d = v[15:0];
    endfunction

    function automatic logic [15:0] model_d(input logic [31:0] x, input int sh);
        logic [15:0] d;
        bit s;
        model(x, sh, 16, d, s);
        return d;
    endfunction

    typedef struct packed { logic [15:0] d; logic s; } exp_t;
    exp_t        q[$];
    logic [15:0] m_last = '0;
    longint      m_cnt  = 0;
    bit          m_flag = 1'b0;
    bit          rx_on  = 1'b0;
    logic [15:0] rx[$];

    // Scoreboard for dut_a, sampled mid-cycle where inputs and outputs are stable.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] d;
        bit s;
        if (!rst_n) begin
            q.delete();
            m_last = '0;
            m_cnt  = 0;
            m_flag = 1'b0;
        end else begin
            chk("in_ready", ifa.in_ready, !(ifa.out_valid && !ifa.out_ready));
            chk("sat_cnt", ifa.sat_cnt, m_cnt);
            chk("sat_flag", ifa.sat_flag, m_flag);
            if (!ifa.out_valid) chk("dout_hold", ifa.D_out, m_last);
            if (ifa.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("dout", ifa.D_out, q[0].d);
                    if (ifa.out_ready) begin
                        e = q.pop_front();
                        m_last = e.d;
                        if (e.s) begin
                            m_flag = 1'b1;
                            if (m_cnt < 16'hFFFF) m_cnt++;
                        end
                        if (rx_on) rx.push_back(ifa.D_out);
                    end
                end
            end
            if (ifa.in_valid && ifa.in_ready) begin
                model(ifa.D_in, 8, 16, d, s);
                q.push_back('{d: d, s: s});
            end
        end
    end

    task automatic send_a(input logic [31:0] x, input logic [15:0] exp, input string name);
        chk({name, "_model"}, model_d(x, 8), exp);
        ifa.D_in = x; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
        chk({name, "_valid"}, ifa.out_valid, 1);
        chk({name, "_dout"}, ifa.D_out, exp);
        @(posedge clk); #1;
    endtask

    task automatic send_c(input logic [31:0] x, input logic [15:0] exp, input string name);
        ifc.D_in = x; ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
        chk({name, "_valid"}, ifc.out_valid, 1);
        chk({name, "_dout"}, ifc.D_out, exp);
        @(posedge clk); #1;
    endtask

    task automatic sat_b(input int n);
        ifb.D_in = 32'h0080_0000;
        ifb.in_valid = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        ifb.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  guard;
        bit  acc;
        ifa.D_in = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.sat_clr = 1'b0;
        ifb.D_in = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.sat_clr = 1'b0;
        ifc.D_in = '0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; ifc.sat_clr = 1'b0;
        #1;
        chk("rst_in_ready", ifa.in_ready, 1);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_dout", ifa.D_out, 0);
        chk("rst_sat_cnt", ifa.sat_cnt, 0);
        chk("rst_sat_flag", ifa.sat_flag, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send_a(32'h0000_1234, 16'h0012, "rnd_1234");
        send_a(32'h0000_1280, 16'h0013, "rnd_1280");
        send_a(32'hFFFF_FF80, 16'h0000, "rnd_m128");
        send_a(32'hFFFF_FF7F, 16'hFFFF, "rnd_m129");
        chk("no_sat_yet", ifa.sat_flag, 0);
        send_a(32'h0080_0000, 16'h7FFF, "sat_pos");
        chk("sat_pos_flag", ifa.sat_flag, 1);
        chk("sat_pos_cnt", ifa.sat_cnt, 1);
        send_a(32'hFF80_0000, 16'h8000, "min_exact");
        chk("min_exact_cnt", ifa.sat_cnt, 1);
        send_a(32'hFF7F_FF00, 16'h8000, "sat_neg");
        chk("sat_neg_cnt", ifa.sat_cnt, 2);
        send_a(32'h7FFF_FFFF, 16'h7FFF, "sat_max_nowrap");
        chk("sat_max_cnt", ifa.sat_cnt, 3);

        // Backpressure stream with out_ready toggling every 3 cycles.
        rx.delete();
        rx_on = 1'b1;
        fork
            begin
                for (int i = 1; i <= 10; i++) begin
                    ifa.D_in = 32'(i) << 8;
                    ifa.in_valid = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = ifa.in_ready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!acc && guard < 50);
                    if (!acc) chk("bp_accept_timeout", 0, 1);
                end
                ifa.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 45; c++) begin
                    ifa.out_ready = ((c / 3) % 2) == 0;
                    @(posedge clk); #1;
                end
                ifa.out_ready = 1'b1;
            end
        join
        guard = 0;
        while (q.size() != 0 && guard < 20) begin @(posedge clk); #1; guard++; end
        rx_on = 1'b0;
        chk("bp_count", rx.size(), 10);
        for (int i = 0; i < rx.size() && i < 10; i++) chk("bp_seq", rx[i], i + 1);

        // Counter width 4 saturates and sticks.
        sat_b(20);
        chk("cnt4_stick", ifb.sat_cnt, 4'hF);
        chk("cnt4_flag", ifb.sat_flag, 1);
        ifb.sat_clr = 1'b1;
        @(posedge clk); #1;
        ifb.sat_clr = 1'b0;
        chk("clr_cnt", ifb.sat_cnt, 0);
        chk("clr_flag", ifb.sat_flag, 0);
        sat_b(2);
        chk("cnt4_two", ifb.sat_cnt, 2);
        ifb.D_in = 32'h0080_0000; ifb.in_valid = 1'b1;
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clr_hs_valid", ifb.out_valid, 1);
        ifb.sat_clr = 1'b1;
        @(posedge clk); #1;
        ifb.sat_clr = 1'b0;
        chk("clr_hs_cnt", ifb.sat_cnt, 1);
        chk("clr_hs_flag", ifb.sat_flag, 1);

        // Zero-shift build: pure saturation.
        send_c(32'h0000_7FFF, 16'h7FFF, "rs0_max");
        chk("rs0_max_flag", ifc.sat_flag, 0);
        send_c(32'h0000_8000, 16'h7FFF, "rs0_sat");
        chk("rs0_sat_flag", ifc.sat_flag, 1);
        chk("rs0_sat_cnt", ifc.sat_cnt, 1);

        // Reset with two words in flight.
        ifa.out_ready = 1'b0;
        ifa.D_in = 32'h0080_0000; ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.D_in = 32'h0000_1234;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", ifa.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ifa.out_valid, 0);
        chk("mid_rst_dout", ifa.D_out, 0);
        chk("mid_rst_cnt", ifa.sat_cnt, 0);
        chk("mid_rst_flag", ifa.sat_flag, 0);
        chk("mid_rst_in_ready", ifa.in_ready, 1);
        @(posedge clk); #1;
        ifa.out_ready = 1'b1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_no_stale", ifa.out_valid, 0);
        end
        @(posedge clk); #1;
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
